// File: rtl/ring_counter_ext.sv
// Ring / Johnson counter with direction control, parallel load, wrap pulse and legality flag.
// Optional build macro RING_SELFCORRECT_EN: illegal states are forced back to the home value.
module ring_counter_ext #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Dir,
    input  logic             Mode,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_value,
    output logic [WIDTH-1:0] Count_out,
    output logic             Wrap,
    output logic             Illegal
);

    localparam logic [WIDTH-1:0] RING_HOME = WIDTH'(1);
    localparam logic [WIDTH-1:0] JOHN_HOME = '0;

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             mode_q;
    logic [WIDTH-1:0] home;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] count_inv;
    logic             ring_legal;
    logic             john_legal;
    logic             mode_change;

    assign home        = Mode ? JOHN_HOME : RING_HOME;
    assign mode_change = (Mode != mode_q);
    assign count_inv   = ~count_q;

    // One-hot check for ring; Johnson patterns are 0..01..1 or 1..10..0.
    assign ring_legal = (count_q != '0) && ((count_q & (count_q - WIDTH'(1))) == '0);
    assign john_legal = ((count_q & (count_q + WIDTH'(1))) == '0) ||
                        ((count_inv & (count_inv + WIDTH'(1))) == '0);
    assign Illegal    = Mode ? ~john_legal : ~ring_legal;

    always_comb begin
        shifted = count_q;
        case ({Mode, Dir})
            2'b00:   shifted = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
            2'b01:   shifted = {count_q[0], count_q[WIDTH-1:1]};
            2'b10:   shifted = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
            default: shifted = {~count_q[0], count_q[WIDTH-1:1]};
        endcase
    end

    // Next state: mode change > load > (self-correct) > shift > hold.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (mode_change) begin
            count_d = home;
        end else if (Load) begin
            count_d = Load_value;
`ifdef RING_SELFCORRECT_EN
        end else if (Illegal) begin
            count_d = home;
`endif
        end else if (Enable) begin
            count_d = shifted;
            wrap_d  = (shifted == home);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= home;
            wrap_q  <= 1'b0;
            mode_q  <= Mode;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            mode_q  <= Mode;
        end
    end

    assign Count_out = count_q;
    assign Wrap      = wrap_q;

endmodule

// File: tb/tb_ring_counter_ext.sv
// Directed self-checking bench for ring_counter_ext at WIDTH=4.
module tb_ring_counter_ext;

    localparam int unsigned W = 4;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         Enable = 1'b0;
    logic         Dir = 1'b0;
    logic         Mode = 1'b0;
    logic         Load = 1'b0;
    logic [W-1:0] Load_value = '0;
    logic [W-1:0] Count_out;
    logic         Wrap;
    logic         Illegal;

    int total = 0;
    int passed = 0;

    ring_counter_ext #(.WIDTH(W)) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Dir(Dir), .Mode(Mode),
        .Load(Load), .Load_value(Load_value), .Count_out(Count_out),
        .Wrap(Wrap), .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset(input logic m);
        Reset = 1'b1; Mode = m; Enable = 1'b0; Load = 1'b0; Dir = 1'b0;
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Mode = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        total++;
        if (Count_out !== 4'b0001) $display("FAIL reset_count got=%b exp=0001", Count_out);
        else passed++;
        total++;
        if (Wrap !== 1'b0) $display("FAIL reset_wrap got=%b exp=0", Wrap);
        else passed++;
        total++;
        if (Illegal !== 1'b0) $display("FAIL reset_illegal got=%b exp=0", Illegal);
        else passed++;
    endtask

    task automatic test_ring_left();
        logic [W-1:0] exp_c [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic         exp_w [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        Enable = 1'b1; Dir = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (Count_out !== exp_c[i] || Wrap !== exp_w[i])
                $display("FAIL ring_left step%0d got=%b/%b exp=%b/%b", i, Count_out, Wrap, exp_c[i], exp_w[i]);
            else passed++;
        end
        Enable = 1'b0;
        tick();
        total++;
        if (Count_out !== 4'b0001 || Wrap !== 1'b0)
            $display("FAIL ring_wrap_drop got=%b/%b exp=0001/0", Count_out, Wrap);
        else passed++;
    endtask

    task automatic test_johnson();
        logic [W-1:0] exp_c [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                    4'b1110, 4'b1100, 4'b1000, 4'b0000};
        do_reset(1'b1);
        total++;
        if (Count_out !== 4'b0000 || Wrap !== 1'b0 || Illegal !== 1'b0)
            $display("FAIL johnson_reset got=%b/%b/%b exp=0000/0/0", Count_out, Wrap, Illegal);
        else passed++;
        Enable = 1'b1; Dir = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (Count_out !== exp_c[i] || Wrap !== (i == 7) || Illegal !== 1'b0)
                $display("FAIL johnson step%0d got=%b/%b/%b exp=%b/%b/0", i, Count_out, Wrap, Illegal,
                         exp_c[i], (i == 7));
            else passed++;
        end
        Dir = 1'b1;
        tick();
        total++;
        if (Count_out !== 4'b1000 || Wrap !== 1'b0)
            $display("FAIL johnson_right got=%b/%b exp=1000/0", Count_out, Wrap);
        else passed++;
        Enable = 1'b0;
    endtask

    task automatic test_dir_hold();
        do_reset(1'b0);
        Enable = 1'b1; Dir = 1'b1;
        tick();
        total++;
        if (Count_out !== 4'b1000) $display("FAIL dir_right1 got=%b exp=1000", Count_out);
        else passed++;
        tick();
        total++;
        if (Count_out !== 4'b0100) $display("FAIL dir_right2 got=%b exp=0100", Count_out);
        else passed++;
        Enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (Count_out !== 4'b0100 || Wrap !== 1'b0)
                $display("FAIL hold%0d got=%b/%b exp=0100/0", i, Count_out, Wrap);
            else passed++;
        end
        Enable = 1'b1; Dir = 1'b0;
        tick();
        total++;
        if (Count_out !== 4'b1000) $display("FAIL dir_toggle got=%b exp=1000", Count_out);
        else passed++;
        Enable = 1'b0;
    endtask

    task automatic test_load_illegal();
        do_reset(1'b0);
        Load = 1'b1; Load_value = 4'b0110; Enable = 1'b0;
        tick();
        Load = 1'b0;
        total++;
        if (Count_out !== 4'b0110 || Illegal !== 1'b1 || Wrap !== 1'b0)
            $display("FAIL load_illegal got=%b/%b/%b exp=0110/1/0", Count_out, Illegal, Wrap);
        else passed++;
        Enable = 1'b1;
        tick();
        total++;
`ifdef RING_SELFCORRECT_EN
        if (Count_out !== 4'b0001 || Illegal !== 1'b0 || Wrap !== 1'b0)
            $display("FAIL selfcorrect got=%b/%b/%b exp=0001/0/0", Count_out, Illegal, Wrap);
        else passed++;
`else
        if (Count_out !== 4'b1100 || Illegal !== 1'b1 || Wrap !== 1'b0)
            $display("FAIL illegal_shift got=%b/%b/%b exp=1100/1/0", Count_out, Illegal, Wrap);
        else passed++;
`endif
        Enable = 1'b0;
    endtask

    task automatic test_mode_change();
        do_reset(1'b0);
        Enable = 1'b1;
        tick();
        tick();
        Enable = 1'b0; Mode = 1'b1;
        tick();
        total++;
        if (Count_out !== 4'b0000 || Wrap !== 1'b0 || Illegal !== 1'b0)
            $display("FAIL mode_to_johnson got=%b/%b/%b exp=0000/0/0", Count_out, Wrap, Illegal);
        else passed++;
        Mode = 1'b0; Load = 1'b1; Load_value = 4'b1000; Enable = 1'b1;
        tick();
        Load = 1'b0; Enable = 1'b0;
        total++;
        if (Count_out !== 4'b0001 || Wrap !== 1'b0)
            $display("FAIL mode_over_load got=%b/%b exp=0001/0", Count_out, Wrap);
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        Load = 1'b1; Load_value = 4'b1000; Enable = 1'b1;
        tick();
        total++;
        if (Count_out !== 4'b1000 || Wrap !== 1'b0)
            $display("FAIL b2b_load got=%b/%b exp=1000/0", Count_out, Wrap);
        else passed++;
        Load = 1'b0;
        tick();
        total++;
        if (Count_out !== 4'b0001 || Wrap !== 1'b1)
            $display("FAIL b2b_shift got=%b/%b exp=0001/1", Count_out, Wrap);
        else passed++;
        Enable = 1'b0;
    endtask

    task automatic test_reset_priority();
        do_reset(1'b0);
        Enable = 1'b1;
        tick();
        Reset = 1'b1; Load = 1'b1; Load_value = 4'b1000;
        tick();
        total++;
        if (Count_out !== 4'b0001 || Wrap !== 1'b0)
            $display("FAIL reset_over_load got=%b/%b exp=0001/0", Count_out, Wrap);
        else passed++;
        Mode = 1'b1;
        tick();
        total++;
        if (Count_out !== 4'b0000 || Wrap !== 1'b0)
            $display("FAIL reset_over_mode got=%b/%b exp=0000/0", Count_out, Wrap);
        else passed++;
        Reset = 1'b0; Load = 1'b0; Enable = 1'b1;
        tick();
        total++;
        if (Count_out !== 4'b0001 || Illegal !== 1'b0)
            $display("FAIL after_reset_mode got=%b/%b exp=0001/0", Count_out, Illegal);
        else passed++;
        Enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ring_left();
        test_johnson();
        test_dir_hold();
        test_load_illegal();
        test_mode_change();
        test_back_to_back();
        test_reset_priority();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ring_counter_ext.md
RING_COUNTER_EXT -- requirements
Module: ring_counter_ext

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 SHALL have port Clock, input, 1: rising-edge clock for all state.
REQ-003 SHALL have port Reset, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port Enable, input, 1: shift enable; when 0, state holds.
REQ-005 SHALL have port Dir, input, 1: shift direction; 0 = left (toward MSB), 1 = right.
REQ-006 SHALL have port Mode, input, 1: 0 = ring (one-hot), 1 = Johnson (twisted ring).
REQ-007 SHALL have port Load, input, 1: parallel load strobe.
REQ-008 SHALL have port Load_value, input, WIDTH: value captured on Load.
REQ-009 SHALL have port Count_out, output, WIDTH: registered counter state.
REQ-010 SHALL have port Wrap, output, 1: registered one-cycle pulse on return to the mode's home value.
REQ-011 SHALL have port Illegal, output, 1: combinational flag, set when Count_out is not a legal pattern for the current Mode.

Function
REQ-012 Home value SHALL be one at bit 0 with all other bits zero in ring mode, and all-zeros in Johnson mode.
REQ-013 Ring left shift SHALL be {q[W-2:0], q[W-1]}; ring right shift SHALL be {q[0], q[W-1:1]}.
REQ-014 Johnson left shift SHALL be {q[W-2:0], ~q[W-1]}; Johnson right shift SHALL be {~q[0], q[W-1:1]}.
REQ-015 Per-edge priority SHALL be: Reset > Mode change > Load > self-correction (REQ-025) > Enable shift > hold.
REQ-016 Mode change is defined as Mode differing from its value at the previous edge; it SHALL load the new mode's home value on that edge, irrespective of Enable and Load.
REQ-017 Load SHALL capture Load_value verbatim on that edge, even if illegal, irrespective of Enable.
REQ-018 Wrap SHALL be 1 for exactly the cycle after an Enable shift produces the home value; reset, load and mode change SHALL NOT raise Wrap.
REQ-019 Ring legal set SHALL be exactly-one-bit-set values; Johnson legal set SHALL be the 2*WIDTH values reachable from all-zeros by left Johnson shifts.
REQ-020 Dir may change on any cycle and SHALL take effect on the next enabled shift with no lost or extra step.
REQ-021 Period SHALL be WIDTH shifts in ring mode and 2*WIDTH shifts in Johnson mode, in either direction.

Reset
REQ-022 On a Clock edge with Reset=1, Count_out SHALL become the home value for the current Mode, Wrap SHALL become 0, and the stored previous Mode SHALL become the current Mode.
REQ-023 Reset asserted mid-count SHALL override Load, Enable and Mode change on that edge.
REQ-024 Illegal SHALL be 0 after reset.

Configuration
REQ-025 With RING_SELFCORRECT_EN defined, an edge with Illegal=1 and no Reset, Mode change or Load SHALL load the home value, irrespective of Enable, with Wrap=0.
REQ-026 Without RING_SELFCORRECT_EN, illegal states SHALL shift and hold like legal ones, and Illegal SHALL continue to flag them; no correction logic SHALL be present.

Verification (WIDTH=4)
REQ-027 Reset=1 for 2 edges, Mode=0 -> Count_out=0001, Wrap=0, Illegal=0; then Enable=1, Dir=0 -> 0010, 0100, 1000, 0001, with Wrap=1 only in the cycle after the 4th edge.
REQ-028 Mode=1 from reset, Enable=1, Dir=0 -> 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, with Wrap=1 after the 8th edge only.
REQ-029 Mode=0, Dir=1 from 0001 -> 1000, 0100; Enable=0 for 3 edges -> holds at 0100; Dir toggled to 0 -> 1000.
REQ-030 Load=1, Load_value=0110, Mode=0 -> Count_out=0110, Illegal=1; next edge with Enable=1: with macro -> 0001, Illegal=0; without macro -> 1100, Illegal=1.
REQ-031 Ring at 0100, Mode switched to 1 with Enable=0 -> next edge Count_out=0000, Wrap=0, Illegal=0.
REQ-032 Reset=1 together with Load=1, Load_value=1000 and Enable=1 -> Count_out = home value, Wrap=0.
